// File: rtl/io_rx_framer.sv
// io_rx_framer: turns a UART byte stream into bus writes.
// A frame is SYNC, CMD, ADDR_H, ADDR_L, LEN, 2*LEN data bytes and an XOR checksum.
// Words are buffered and only put on the bus once the checksum has matched.
module io_rx_framer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter int          MAX_WORDS      = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_byte,
    input  logic        received,
    output logic        io_stb_o,
    output logic        io_we_o,
    output logic [15:0] io_addr_o,
    output logic [15:0] io_dat_o,
    input  logic        io_ack_i,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam logic [7:0] SYNC   = 8'hA5;
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam int         AW     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_LEN,
        S_DATA_H, S_DATA_L, S_CSUM, S_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] tmo_q, tmo_d;
    logic [15:0] base_q, base_d;
    logic [7:0]  hi_q, hi_d;
    logic        stb_q, stb_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] dat_q, dat_d;
    logic        ok_q, ok_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic        busy_q, busy_d;

    // Word buffer: no reset, every slot read in WRITE was written earlier in the same frame.
    logic [15:0]   mem_q [MAX_WORDS];
    logic          mem_we;
    logic [AW-1:0] mem_idx;
    logic [15:0]   mem_wdata;
    logic          counting;

    assign mem_idx  = idx_q[AW-1:0];
    assign counting = (state_q != S_IDLE) && (state_q != S_WRITE);

    // Next-state: frame parsing, bus handshake and inter-byte timeout.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        csum_d    = csum_q;
        tmo_d     = tmo_q;
        base_d    = base_q;
        hi_d      = hi_q;
        stb_d     = stb_q;
        addr_d    = addr_q;
        dat_d     = dat_q;
        ok_d      = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        mem_we    = 1'b0;
        mem_wdata = {hi_q, rx_byte};

        case (state_q)
            S_IDLE: begin
                if (received && rx_byte == SYNC) begin
                    state_d = S_CMD;
                    csum_d  = 8'h00;
                    idx_d   = 8'h00;
                end
            end
            S_CMD: begin
                if (received) begin
                    if (rx_byte == CMD_WR) begin
                        csum_d  = csum_q ^ rx_byte;
                        state_d = S_ADDR_H;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                        state_d = S_IDLE;
                    end
                end
            end
            S_ADDR_H: begin
                if (received) begin
                    base_d[15:8] = rx_byte;
                    csum_d       = csum_q ^ rx_byte;
                    state_d      = S_ADDR_L;
                end
            end
            S_ADDR_L: begin
                if (received) begin
                    base_d[7:0] = rx_byte;
                    csum_d      = csum_q ^ rx_byte;
                    state_d     = S_LEN;
                end
            end
            S_LEN: begin
                if (received) begin
                    if (rx_byte == 8'h00 || int'(rx_byte) > MAX_WORDS) begin
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                        state_d = S_IDLE;
                    end else begin
                        len_d   = rx_byte;
                        csum_d  = csum_q ^ rx_byte;
                        idx_d   = 8'h00;
                        state_d = S_DATA_H;
                    end
                end
            end
            S_DATA_H: begin
                if (received) begin
                    hi_d    = rx_byte;
                    csum_d  = csum_q ^ rx_byte;
                    state_d = S_DATA_L;
                end
            end
            S_DATA_L: begin
                if (received) begin
                    mem_we  = 1'b1;
                    csum_d  = csum_q ^ rx_byte;
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q + 8'd1 == len_q) ? S_CSUM : S_DATA_H;
                end
            end
            S_CSUM: begin
                if (received) begin
                    if (rx_byte == csum_q) begin
                        state_d = S_WRITE;
                        idx_d   = 8'h00;
                        stb_d   = 1'b1;
                        addr_d  = base_q;
                        dat_d   = mem_q[0];
                    end else begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                // Bytes arriving here are dropped; a strobe-low cycle separates words.
                if (stb_q) begin
                    if (io_ack_i) begin
                        stb_d = 1'b0;
                        idx_d = idx_q + 8'd1;
                        if (idx_q == len_q - 8'd1) begin
                            ok_d    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end else begin
                    stb_d  = 1'b1;
                    addr_d = base_q + {7'b0, idx_q, 1'b0};
                    dat_d  = mem_q[mem_idx];
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abandon a half-received frame once the line has been idle too long.
        if (counting && !received && tmo_q == TIMEOUT_CYCLES - 16'd1) begin
            err_d   = 1'b1;
            code_d  = 2'd3;
            state_d = S_IDLE;
        end

        if (state_d == S_IDLE || state_d == S_WRITE || received)
            tmo_d = 16'h0000;
        else
            tmo_d = tmo_q + 16'd1;

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= 8'h00;
            len_q   <= 8'h00;
            csum_q  <= 8'h00;
            tmo_q   <= 16'h0000;
            base_q  <= 16'h0000;
            hi_q    <= 8'h00;
            stb_q   <= 1'b0;
            addr_q  <= 16'h0000;
            dat_q   <= 16'h0000;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            base_q  <= base_d;
            hi_q    <= hi_d;
            stb_q   <= stb_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
        end
    end

    // Buffer write port, one word per DATA_L byte.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[mem_idx] <= mem_wdata;
    end

    assign io_stb_o  = stb_q;
    assign io_we_o   = stb_q;
    assign io_addr_o = addr_q;
    assign io_dat_o  = dat_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = code_q;
    assign busy      = busy_q;

endmodule
